// File: rtl/branch_resolver.sv
// Branch resolver: tracks in-flight predicted branches in fetch order and resolves the oldest one.
// Produces a registered predictor update strobe and saturating statistics counters.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic                     prediction,
  output logic                     pred_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     request,
  output logic                     taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic [CNT_W-1:0]         branch_count,
  output logic [CNT_W-1:0]         mispredict_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [DEPTH-1:0] pred_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ_nxt;
  logic             push;
  logic             pop;
  logic             head;
  logic             miss;

  // Readiness depends only on current occupancy, so a pop never frees a slot in the same cycle.
  assign pred_ready = (inflight < OCC_FULL);
  assign push       = pred_valid & pred_ready;
  assign pop        = resolve_valid & (inflight != '0);
  assign head       = pred_q[rd_ptr];
  assign miss       = pop & (head != resolve_taken);

  always_comb begin
    occ_nxt = inflight;
    if (miss) begin
      occ_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   occ_nxt = inflight + 1'b1;
        2'b01:   occ_nxt = inflight - 1'b1;
        default: occ_nxt = inflight;
      endcase
    end
  end

  // A mispredict flushes the wrong-path entries and drops any same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      inflight <= occ_nxt;
      if (miss) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          pred_q[wr_ptr] <= prediction;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      request    <= 1'b0;
      taken      <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      request    <= pop;
      taken      <= pop & resolve_taken;
      mispredict <= miss;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (pop && (branch_count != CNT_MAX)) begin
        branch_count <= branch_count + 1'b1;
      end
      if (miss && (mispredict_count != CNT_MAX)) begin
        mispredict_count <= mispredict_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: vector table for steady-state behaviour,
// hand-written sequences for reset, first-push and counter saturation.
module tb_branch_resolver;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             pred_valid;
  logic             prediction;
  logic             pred_ready;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             request;
  logic             taken;
  logic             mispredict;
  logic [2:0]       inflight;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  int errors = 0;
  int checks = 0;

  branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pred_valid       (pred_valid),
    .prediction       (prediction),
    .pred_ready       (pred_ready),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .request          (request),
    .taken            (taken),
    .mispredict       (mispredict),
    .inflight         (inflight),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pv;
    int pr;
    int rv;
    int rt;
    int e_req;
    int e_tk;
    int e_mp;
    int e_inf;
    int e_rdy;
    int e_bc;
    int e_mc;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic pr, input logic rv, input logic rt);
    pred_valid    = pv;
    prediction    = pr;
    resolve_valid = rv;
    resolve_taken = rt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int e_req, input int e_tk, input int e_mp,
                           input int e_inf, input int e_rdy, input int e_bc, input int e_mc);
    check({tag, ".request"},    int'(request),          e_req);
    check({tag, ".taken"},      int'(taken),            e_tk);
    check({tag, ".mispredict"}, int'(mispredict),       e_mp);
    check({tag, ".inflight"},   int'(inflight),         e_inf);
    check({tag, ".pred_ready"}, int'(pred_ready),       e_rdy);
    check({tag, ".branch_cnt"}, int'(branch_count),     e_bc);
    check({tag, ".mispred_cnt"},int'(mispredict_count), e_mc);
  endtask

  initial begin
    //           pv pr rv rt  req tk mp inf rdy bc mc
    vecs[0]  = '{1, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0};
    vecs[1]  = '{1, 0, 0, 0,  0, 0, 0, 2, 1, 0, 0};
    vecs[2]  = '{1, 1, 0, 0,  0, 0, 0, 3, 1, 0, 0};
    vecs[3]  = '{0, 0, 1, 1,  1, 1, 0, 2, 1, 1, 0};
    vecs[4]  = '{0, 0, 1, 0,  1, 0, 0, 1, 1, 2, 0};
    vecs[5]  = '{0, 0, 1, 1,  1, 1, 0, 0, 1, 3, 0};
    vecs[6]  = '{0, 0, 0, 0,  0, 0, 0, 0, 1, 3, 0};
    vecs[7]  = '{0, 0, 1, 1,  0, 0, 0, 0, 1, 3, 0};
    vecs[8]  = '{0, 0, 1, 0,  0, 0, 0, 0, 1, 3, 0};
    vecs[9]  = '{1, 0, 0, 0,  0, 0, 0, 1, 1, 3, 0};
    vecs[10] = '{1, 1, 0, 0,  0, 0, 0, 2, 1, 3, 0};
    vecs[11] = '{1, 1, 0, 0,  0, 0, 0, 3, 1, 3, 0};
    vecs[12] = '{1, 0, 0, 0,  0, 0, 0, 4, 0, 3, 0};
    vecs[13] = '{1, 1, 0, 0,  0, 0, 0, 4, 0, 3, 0};
    vecs[14] = '{1, 1, 1, 0,  1, 0, 0, 3, 1, 4, 0};
    vecs[15] = '{1, 1, 1, 1,  1, 1, 0, 3, 1, 5, 0};
    vecs[16] = '{0, 0, 1, 1,  1, 1, 0, 2, 1, 6, 0};
    vecs[17] = '{0, 0, 1, 0,  1, 0, 0, 1, 1, 7, 0};
    vecs[18] = '{0, 0, 1, 1,  1, 1, 0, 0, 1, 8, 0};
    vecs[19] = '{1, 1, 0, 0,  0, 0, 0, 1, 1, 8, 0};
    vecs[20] = '{1, 1, 0, 0,  0, 0, 0, 2, 1, 8, 0};
    vecs[21] = '{1, 1, 0, 0,  0, 0, 0, 3, 1, 8, 0};
    vecs[22] = '{1, 1, 1, 0,  1, 0, 1, 0, 1, 9, 1};
    vecs[23] = '{0, 0, 0, 0,  0, 0, 0, 0, 1, 9, 1};
    vecs[24] = '{1, 0, 0, 0,  0, 0, 0, 1, 1, 9, 1};
    vecs[25] = '{0, 0, 1, 1,  1, 1, 1, 0, 1, 10, 2};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all("reset", 0, 0, 0, 0, 1, 0, 0);
    tick();
    check_all("reset_clk", 0, 0, 0, 0, 1, 0, 0);

    // First push must land on the very first edge with reset released.
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check("first_push.inflight", int'(inflight), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_all("first_push.resolve", 1, 1, 0, 0, 1, 1, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].pv[0], vecs[i].pr[0], vecs[i].rv[0], vecs[i].rt[0]);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_tk, vecs[i].e_mp,
                vecs[i].e_inf, vecs[i].e_rdy, vecs[i].e_bc, vecs[i].e_mc);
    end

    // Mid-operation reset: asserted between edges while request is high.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("midrst.pre_request", int'(request), 1);
    check("midrst.pre_inflight", int'(inflight), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("midrst.async", 0, 0, 0, 0, 1, 0, 0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("midrst.after%0d", i), 0, 0, 0, 0, 1, 0, 0);
    end

    // Branch counter saturation: 18 correct resolves, holds at 15.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 18; i++) begin
      tick();
      check($sformatf("sat_bc%0d", i), int'(branch_count), (i + 1 > 15) ? 15 : i + 1);
      check($sformatf("sat_req%0d", i), int'(request), 1);
    end
    check("sat.inflight", int'(inflight), 1);
    check("sat.mispred_cnt", int'(mispredict_count), 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("sat.drain_inflight", int'(inflight), 0);

    // Mispredict counter saturation: 17 wrong predictions.
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      check($sformatf("sat_mc%0d", k), int'(mispredict_count), (k + 1 > 15) ? 15 : k + 1);
      check($sformatf("sat_mp%0d", k), int'(mispredict), 1);
    end
    check("sat.bc_hold", int'(branch_count), 15);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("final", 0, 0, 0, 0, 1, 15, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of in-flight predicted branches held (power of two, 2..16).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of both statistics counters.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 pred_valid  input  1  SHALL mark a fetched branch carrying a prediction this cycle.
REQ-006 prediction  input  1  SHALL be the predictor's direction for that branch (1 = taken).
REQ-007 pred_ready  output  1  SHALL be high when the in-flight buffer can accept a branch.
REQ-008 resolve_valid  input  1  SHALL mark that execute has resolved the oldest in-flight branch.
REQ-009 resolve_taken  input  1  SHALL be the actual outcome of that branch.
REQ-010 request  output  1  SHALL be the registered update strobe to the predictor.
REQ-011 taken  output  1  SHALL be the registered actual outcome sent with request.
REQ-012 mispredict  output  1  SHALL be a one-cycle pulse, aligned with request, when prediction != outcome.
REQ-013 inflight  output  $clog2(DEPTH)+1  SHALL be the current buffer occupancy.
REQ-014 branch_count  output  CNT_W  SHALL count resolved branches.
REQ-015 mispredict_count  output  CNT_W  SHALL count mispredicted branches.

Function
REQ-016 Predictions SHALL be held in a DEPTH-entry FIFO in fetch order; head = oldest unresolved branch.
REQ-017 pred_ready SHALL be combinational: inflight < DEPTH; no same-cycle pop-to-push bypass.
REQ-018 Push SHALL occur when pred_valid && pred_ready; pred_valid while full SHALL be dropped, state unchanged.
REQ-019 Pop SHALL occur when resolve_valid && inflight != 0; the head is compared to resolve_taken.
REQ-020 On a pop, the next cycle SHALL present request=1, taken=resolve_taken, mispredict=(head != resolve_taken); latency exactly 1 cycle.
REQ-021 request, taken, mispredict SHALL be 0 in any cycle not following a pop; taken is 0 when request is 0.
REQ-022 resolve_valid with inflight == 0 SHALL be ignored: no pop, no request, no counter change.
REQ-023 Pop without mispredict plus simultaneous push SHALL leave inflight unchanged, with the new entry appended behind the remaining entries.
REQ-024 Pop with mispredict SHALL discard all younger entries (wrong path) and any same-cycle push; inflight SHALL be 0 the next cycle.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH or go below 0.
REQ-026 branch_count SHALL increment by 1 per pop; mispredict_count by 1 per mispredicting pop; both SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 Both counters SHALL update in the same cycle that request/mispredict assert.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear FIFO pointers, inflight=0, request=0, taken=0, mispredict=0, branch_count=0, mispredict_count=0, regardless of clk.
REQ-029 pred_ready SHALL be 1 while and after reset (buffer empty).
REQ-030 Reset asserted mid-operation SHALL discard all in-flight entries; no update pulse SHALL be emitted for them after release.
REQ-031 First push SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-032 Push predictions 1,0,1; resolve 1,0,1 one per cycle -> three request pulses, taken 1,0,1, mispredict never, branch_count=3, mispredict_count=0, inflight ends 0.
REQ-033 Push 4 entries (DEPTH=4) then pred_valid again -> pred_ready=0, fifth dropped, inflight=4; one resolve -> inflight=3, pred_ready=1.
REQ-034 Push 1,1,1; resolve first with resolve_taken=0 while pushing -> next cycle request=1, taken=0, mispredict=1, inflight=0, mispredict_count=1.
REQ-035 inflight=0, assert resolve_valid=1 -> request stays 0, counters unchanged.
REQ-036 Push 2 entries, drop rst_n low between edges -> all outputs 0 and inflight=0 immediately; no request after release.
REQ-037 Preload counters near saturation (CNT_W=4, 16 correct resolves plus 2 more) -> branch_count holds at 15.
